// File: rtl/chain_adder_pkg.sv
// Shared types and constants for the chain_adder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the float word layout, default widths and
// latencies, and a few IEEE-754 single constants used by the bench.
package chain_adder_pkg;

  localparam int FP_WIDTH            = 32;
  localparam int DEFAULT_ADD_LATENCY = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10,
    FINISH = 2'b11
  } state_t;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;

  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_HALF    = 32'h3F00_0000;
  localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
  localparam logic [31:0] FP_TWO     = 32'h4000_0000;
  localparam logic [31:0] FP_THREE   = 32'h4040_0000;
  localparam logic [31:0] FP_FOUR    = 32'h4080_0000;
  localparam logic [31:0] FP_SEVEN   = 32'h40E0_0000;
  localparam logic [31:0] FP_TEN     = 32'h4120_0000;
  localparam logic [31:0] FP_NEG_ONE = 32'hBF80_0000;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

  // Leading-zero count of a 27-bit aligned significand (27 when all zero).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i <= 26; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/chain_adder_if.sv
// Request/result bundle between a producer and chain_adder.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the block is idle.
//
// master: drives start/current_total/terms/term_mask, observes results.
// slave : chain_adder side.
interface chain_adder_if
  import chain_adder_pkg::*;
#(
  parameter int NUM_TERMS        = 3,
  parameter int FLOAT_DATA_WIDTH = FP_WIDTH
);

  logic                                  start;
  logic [FLOAT_DATA_WIDTH-1:0]           current_total;
  logic [NUM_TERMS*FLOAT_DATA_WIDTH-1:0] terms;
  logic [NUM_TERMS-1:0]                  term_mask;
  logic [FLOAT_DATA_WIDTH-1:0]           new_total;
  logic                                  done;
  logic                                  working;

  modport master (
    output start, current_total, terms, term_mask,
    input  new_total, done, working
  );

  modport slave (
    input  start, current_total, terms, term_mask,
    output new_total, done, working
  );

endinterface

// File: rtl/chain_adder_arith.sv
// Arithmetic helpers for chain_adder: pipelined float32 adder and WAIT timer.
// Latency: add = LATENCY cycles from stable operands to valid result; timer = 1.
// Backpressure: both freeze completely while clk_en is low.
//
// add ports          : clk, aclr (sync clear), clk_en, a, b -> result
// latency_timer ports: clk, rst, clk_en, clr, inc -> last
module add
  import chain_adder_pkg::*;
#(
  parameter int LATENCY = DEFAULT_ADD_LATENCY
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  fp32_t       fa, fb;
  logic [30:0] a_mag, b_mag, big_mag, small_mag;
  logic        big_sign, small_sign, is_nan;
  logic [23:0] m_big, m_small;
  logic [7:0]  exp_diff;
  logic [4:0]  shamt, lz;
  logic [50:0] small_wide;
  logic [26:0] x_al, y_al, norm;
  logic [27:0] sum;
  logic [9:0]  exp_n, exp_r;
  logic        round_up;
  logic [24:0] mant_r;
  logic [22:0] frac_r;
  logic [31:0] sum_word;

  always_comb begin
    fa = a;
    fb = b;
    // Subnormal inputs are flushed to zero; magnitude compare picks the
    // larger operand so the aligned subtraction never goes negative.
    a_mag = (fa.exp == 8'd0) ? 31'd0 : {fa.exp, fa.frac};
    b_mag = (fb.exp == 8'd0) ? 31'd0 : {fb.exp, fb.frac};
    if (a_mag >= b_mag) begin
      big_mag = a_mag; big_sign = fa.sign; small_mag = b_mag; small_sign = fb.sign;
    end else begin
      big_mag = b_mag; big_sign = fb.sign; small_mag = a_mag; small_sign = fa.sign;
    end
    m_big    = {big_mag[30:23] != 8'd0, big_mag[22:0]};
    m_small  = {small_mag[30:23] != 8'd0, small_mag[22:0]};
    exp_diff = big_mag[30:23] - small_mag[30:23];
    // Beyond 27 places the small operand only contributes to sticky.
    shamt      = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
    small_wide = {m_small, 27'd0} >> shamt;
    x_al       = {m_big, 3'b000};
    y_al       = {small_wide[50:25], |small_wide[24:0]};
    sum = (big_sign ^ small_sign) ? ({1'b0, x_al} - {1'b0, y_al})
                                  : ({1'b0, x_al} + {1'b0, y_al});
    lz = lzc27(sum[26:0]);
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = {2'b00, big_mag[30:23]} + 10'd1;
    end else begin
      norm  = sum[26:0] << lz;
      exp_n = {2'b00, big_mag[30:23]} - {5'd0, lz};
    end
    // Round to nearest, ties to even, on guard/round/sticky.
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
    exp_r    = mant_r[24] ? exp_n + 10'd1 : exp_n;
    frac_r   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    is_nan = (fa.exp == 8'hFF && fa.frac != 23'd0) ||
             (fb.exp == 8'hFF && fb.frac != 23'd0) ||
             (fa.exp == 8'hFF && fb.exp == 8'hFF && fa.sign != fb.sign);
    // exp_r is two's complement; bit 9 set means it went below zero.
    if (is_nan)                           sum_word = FP_QNAN;
    else if (fa.exp == 8'hFF)             sum_word = a;
    else if (fb.exp == 8'hFF)             sum_word = b;
    else if (sum == 28'd0)                sum_word = FP_ZERO;
    else if (exp_r[9] || exp_r == 10'd0)  sum_word = {big_sign, 31'd0};
    else if (exp_r >= 10'd255)            sum_word = {big_sign, 8'hFF, 23'd0};
    else                                  sum_word = {big_sign, exp_r[7:0], frac_r};
  end

  // LATENCY-1 register stages: the caller holds operands stable and samples
  // the result on the LATENCY-th edge after they were presented.
  generate
    if (LATENCY > 1) begin : g_pipe
      logic [31:0] stage_q [LATENCY-1];
      always_ff @(posedge clk) begin
        if (aclr) begin
          for (int i = 0; i < LATENCY - 1; i++) stage_q[i] <= '0;
        end else if (clk_en) begin
          stage_q[0] <= sum_word;
          for (int i = 1; i < LATENCY - 1; i++) stage_q[i] <= stage_q[i-1];
        end
      end
      assign result = stage_q[LATENCY-2];
    end else begin : g_comb
      assign result = sum_word;
    end
  endgenerate

endmodule

module latency_timer #(
  parameter int LATENCY = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(LATENCY - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clk_en) begin
      if (clr)      count <= '0;
      else if (inc) count <= count + 1'b1;
    end
  end

  assign last = (count == LAST_COUNT);

endmodule

// File: rtl/chain_adder.sv
// Folds NUM_TERMS masked float32 terms into a running total with one shared adder.
// Latency: NUM_TERMS + popcount(mask)*ADD_LATENCY + 1 cycles from accepted start to done.
// Backpressure: start ignored unless idle; clk_en low freezes all state and outputs.
//
// Ports: clk, rst (sync, active high), clk_en (global freeze),
//        bus (chain_adder_if.slave): start/current_total/terms/term_mask in,
//        new_total/done/working out.
module chain_adder
  import chain_adder_pkg::*;
#(
  parameter int NUM_TERMS        = 3,
  parameter int FLOAT_DATA_WIDTH = FP_WIDTH,
  parameter int ADD_LATENCY      = DEFAULT_ADD_LATENCY,
  parameter int IDX_WIDTH        = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  chain_adder_if.slave bus
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_TERMS - 1);

  typedef logic [FLOAT_DATA_WIDTH-1:0] word_t;

  state_t                                state, state_n;
  logic [IDX_WIDTH-1:0]                  idx, idx_n;
  word_t                                 acc, acc_n;
  word_t                                 op_a, op_a_n, op_b, op_b_n;
  word_t                                 new_total_q, new_total_n;
  logic [NUM_TERMS-1:0][FLOAT_DATA_WIDTH-1:0] term_q, term_n;
  logic [NUM_TERMS-1:0]                  mask_q, mask_n;
  logic                                  done_q, done_n;
  logic                                  working_q, working_n;
  logic                                  timer_clr, timer_inc, timer_last;
  logic                                  last_term;
  logic                                  add_en;
  word_t                                 add_result;

  assign last_term = (idx == LAST_IDX);
  // The adder only runs while an operation is in flight.
  assign add_en    = clk_en & working_q;

  add #(
    .LATENCY (ADD_LATENCY)
  ) u_add (
    .clk    (clk),
    .aclr   (rst),
    .clk_en (add_en),
    .a      (op_a),
    .b      (op_b),
    .result (add_result)
  );

  latency_timer #(
    .LATENCY (ADD_LATENCY)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .clr    (timer_clr),
    .inc    (timer_inc),
    .last   (timer_last)
  );

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    acc_n       = acc;
    op_a_n      = op_a;
    op_b_n      = op_b;
    term_n      = term_q;
    mask_n      = mask_q;
    new_total_n = new_total_q;
    done_n      = 1'b0;
    working_n   = working_q;
    timer_clr   = 1'b0;
    timer_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          acc_n     = bus.current_total;
          term_n    = bus.terms;
          mask_n    = bus.term_mask;
          idx_n     = '0;
          working_n = 1'b1;
          state_n   = LAUNCH;
        end
      end
      LAUNCH: begin
        if (mask_q[idx]) begin
          op_a_n    = acc;
          op_b_n    = term_q[idx];
          timer_clr = 1'b1;
          state_n   = WAIT;
        end else if (last_term) begin
          state_n = FINISH;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      WAIT: begin
        // Operands stay parked in op_a/op_b for the whole wait.
        timer_inc = ~timer_last;
        if (timer_last) begin
          acc_n = add_result;
          if (last_term) begin
            state_n = FINISH;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = LAUNCH;
          end
        end
      end
      FINISH: begin
        new_total_n = acc;
        done_n      = 1'b1;
        working_n   = 1'b0;
        state_n     = IDLE;
      end
    endcase
  end

  // Reset wins over clk_en; with clk_en low everything, including a pending
  // done pulse, simply holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      term_q      <= '0;
      mask_q      <= '0;
      new_total_q <= '0;
      done_q      <= 1'b0;
      working_q   <= 1'b0;
    end else if (clk_en) begin
      state       <= state_n;
      idx         <= idx_n;
      acc         <= acc_n;
      op_a        <= op_a_n;
      op_b        <= op_b_n;
      term_q      <= term_n;
      mask_q      <= mask_n;
      new_total_q <= new_total_n;
      done_q      <= done_n;
      working_q   <= working_n;
    end
  end

  assign bus.new_total = new_total_q;
  assign bus.done      = done_q;
  assign bus.working   = working_q;

endmodule

// File: tb/tb_chain_adder.sv
// Randomised self-checking bench for chain_adder against a real-arithmetic model.
// Latency: checks done timing against NUM_TERMS + k*ADD_LATENCY + 1 (+ frozen cycles).
// Backpressure: exercises clk_en freezes, ignored starts, mid-operation reset.
module tb_chain_adder;
  import chain_adder_pkg::*;

  localparam int NT  = 3;
  localparam int LAT = 5;

  logic clk;
  logic rst;
  logic clk_en;
  int   total;
  int   bad;

  chain_adder_if #(.NUM_TERMS(NT), .FLOAT_DATA_WIDTH(32)) bus ();

  chain_adder #(
    .NUM_TERMS        (NT),
    .FLOAT_DATA_WIDTH (32),
    .ADD_LATENCY      (LAT),
    .IDX_WIDTH        (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact value of a float32 as a double (subnormals treated as zero).
  function automatic real fp_to_real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Round a double to float32, nearest-even, by comparing the dropped tail to one half.
  function automatic logic [31:0] real_to_fp(input real r);
    logic [63:0] d;
    logic [52:0] m;
    logic [24:0] keep;
    logic [28:0] tail;
    logic [7:0]  e8;
    if (r == 0.0) return 32'h0;
    d    = $realtobits(r);
    m    = {1'b1, d[51:0]};
    keep = {1'b0, m[52:29]};
    tail = m[28:0];
    if (tail > 29'h1000_0000 || (tail == 29'h1000_0000 && keep[0])) keep = keep + 25'd1;
    e8 = 8'(d[62:52] - 11'd896);
    if (keep[24]) begin
      e8   = e8 + 8'd1;
      keep = keep >> 1;
    end
    return {d[63], e8, keep[22:0]};
  endfunction

  // Values are drawn from a narrow exponent band so every exact sum fits a
  // double; each masked term is then one correctly rounded float add.
  function automatic logic [31:0] model_fold(input logic [31:0] tot,
                                             input logic [NT*32-1:0] tv,
                                             input logic [NT-1:0] m);
    logic [31:0] a;
    a = tot;
    for (int i = 0; i < NT; i++) begin
      if (m[i]) a = real_to_fp(fp_to_real(a) + fp_to_real(tv[i*32 +: 32]));
    end
    return a;
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(1, 0)), 8'($urandom_range(134, 120)), 23'($urandom)};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Entered and left #1 after a rising edge. stall_at/rst_at < 0 disables them.
  task automatic run_op(input string tag, input logic [31:0] tot,
                        input logic [NT*32-1:0] tv, input logic [NT-1:0] m,
                        input int stall_at, input int stall_len, input int rst_at);
    int          cyc;
    int          exp_lat;
    logic [31:0] exp_sum;
    bit          wk_ok;
    bit          saw_done;
    exp_sum = model_fold(tot, tv, m);
    exp_lat = NT + $countones(m) * LAT + 1 + ((stall_at >= 0) ? stall_len : 0);
    bus.start         = 1'b1;
    bus.current_total = tot;
    bus.terms         = tv;
    bus.term_mask     = m;
    step(1);
    bus.start         = 1'b0;
    bus.current_total = rand_fp();
    for (int i = 0; i < NT; i++) bus.terms[i*32 +: 32] = rand_fp();
    bus.term_mask     = ~m;
    check_eq({tag, "_accept_working"}, 32'(bus.working), 32'd1);
    check_eq({tag, "_accept_done_low"}, 32'(bus.done), 32'd0);
    cyc   = 0;
    wk_ok = 1'b1;
    while (!bus.done && cyc < 400) begin
      if (cyc == stall_at) clk_en = 1'b0;
      if (stall_at >= 0 && cyc == stall_at + stall_len) clk_en = 1'b1;
      if (cyc == 2) bus.start = 1'b1;
      if (cyc == 3) bus.start = 1'b0;
      if (cyc == rst_at) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_eq({tag, "_rst_new_total"}, bus.new_total, 32'd0);
        check_eq({tag, "_rst_done"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_rst_working"}, 32'(bus.working), 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
          step(1);
          if (bus.done) saw_done = 1'b1;
        end
        check_eq({tag, "_rst_no_done"}, 32'(saw_done), 32'd0);
        return;
      end
      step(1);
      cyc++;
      if (!bus.done && !bus.working) wk_ok = 1'b0;
    end
    check_eq({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check_eq({tag, "_sum"}, bus.new_total, exp_sum);
    check_eq({tag, "_working_low"}, 32'(bus.working), 32'd0);
    check_eq({tag, "_working_held"}, 32'(wk_ok), 32'd1);
  endtask

  logic [NT*32-1:0] base_terms;
  logic [NT*32-1:0] neg_terms;
  logic [NT*32-1:0] tv;
  logic [31:0]      held;

  initial begin
    total             = 0;
    bad               = 0;
    rst               = 1'b1;
    clk_en            = 1'b1;
    bus.start         = 1'b0;
    bus.current_total = '0;
    bus.terms         = '0;
    bus.term_mask     = '0;
    base_terms        = {FP_FOUR, FP_THREE, FP_TWO};
    neg_terms         = {FP_NEG_ONE, FP_NEG_ONE, FP_NEG_ONE};
    step(3);
    check_eq("reset_new_total", bus.new_total, 32'd0);
    check_eq("reset_done", 32'(bus.done), 32'd0);
    check_eq("reset_working", 32'(bus.working), 32'd0);
    rst = 1'b0;
    step(2);

    run_op("c1", FP_ONE, base_terms, 3'b111, -1, 0, -1);
    check_eq("c1_const", bus.new_total, FP_TEN);
    step(2);
    run_op("c2", FP_ONE, base_terms, 3'b101, -1, 0, -1);
    check_eq("c2_const", bus.new_total, FP_SEVEN);
    step(1);
    run_op("c3", FP_HALF, base_terms, 3'b000, -1, 0, -1);
    check_eq("c3_const", bus.new_total, FP_HALF);
    // A done pulse caught by a freeze stays up until the next enabled edge.
    held   = bus.new_total;
    clk_en = 1'b0;
    step(3);
    check_eq("freeze_done_held", 32'(bus.done), 32'd1);
    check_eq("freeze_total_held", bus.new_total, held);
    clk_en = 1'b1;
    step(1);
    check_eq("freeze_done_drop", 32'(bus.done), 32'd0);

    run_op("c4", FP_ONE, base_terms, 3'b111, 3, 7, -1);
    check_eq("c4_const", bus.new_total, FP_TEN);
    step(1);
    check_eq("c4_no_second_op", 32'(bus.working), 32'd0);
    step(2);
    run_op("c5", FP_ONE, base_terms, 3'b111, -1, 0, 9);
    run_op("c5_fresh", FP_ONE, base_terms, 3'b111, -1, 0, -1);
    check_eq("c5_const", bus.new_total, FP_TEN);
    // Back-to-back: next start driven in the done cycle.
    run_op("c6", FP_THREE, neg_terms, 3'b111, -1, 0, -1);
    check_eq("c6_const", bus.new_total, FP_ZERO);
    step(1);
    check_eq("c6_done_width", 32'(bus.done), 32'd0);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NT; i++) tv[i*32 +: 32] = rand_fp();
      if ($urandom_range(1, 0) == 1)
        run_op("rnd", rand_fp(), tv, 3'($urandom), int'($urandom_range(3, 0)),
               int'($urandom_range(6, 1)), -1);
      else
        run_op("rnd", rand_fp(), tv, 3'($urandom), -1, 0, -1);
      step(int'($urandom_range(2, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
